wdt32_ctrl: RTL and testbench
=============================

WDT32_CTRL -- requirements
Module: wdt32_ctrl

Interface
REQ-001 SHALL have parameter GRACE_CYCLES, default 1024: cycles from first overflow to reset request.
REQ-002 SHALL have parameter RST_PULSE, default 16: width of WDRST_REQ in cycles.
REQ-003 SHALL have port PCLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port PRESET  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port WDLOAD  in  32  reload value from the register block.
REQ-006 SHALL have port WDEN  in  1  enable level from the register block.
REQ-007 SHALL have port WDOVCLR  in  1  service/clear level from the register block; the block acts on its rising edge only.
REQ-008 SHALL have port WDTMR  out  32  current count value.
REQ-009 SHALL have port WDOV  out  1  sticky overflow flag.
REQ-010 SHALL have port WDRST_REQ  out  1  system reset request.
REQ-011 SHALL have port WDSTATE  out  2  current FSM state, for debug readback.

Function
REQ-012 SHALL register all outputs; any input change is visible on the outputs one cycle later.
REQ-013 SHALL detect a service as WDOVCLR=1 with the previous-cycle sample at 0, using one internal flop.
REQ-014 SHALL implement states IDLE(0), COUNT(1), GRACE(2), RESET(3); WDSTATE SHALL equal the state code.
REQ-015 In IDLE: WDTMR SHALL load WDLOAD every cycle; WDEN=1 SHALL move the FSM to COUNT.
REQ-016 In COUNT: WDTMR SHALL decrement by 1 per cycle, with no wrap.
REQ-017 In COUNT with WDTMR==0: SHALL set WDOV=1, reload WDTMR=WDLOAD, load the grace counter with GRACE_CYCLES-1 and enter GRACE.
REQ-018 In GRACE: WDTMR SHALL keep decrementing and reload from WDLOAD at 0 without further effect; the grace counter SHALL decrement each cycle.
REQ-019 Service in COUNT or GRACE: SHALL clear WDOV, reload WDTMR=WDLOAD and enter/stay in COUNT.
REQ-020 Grace counter==0 in GRACE with no service: SHALL enter RESET with WDRST_REQ=1 for exactly RST_PULSE cycles, then enter IDLE with WDOV still 1.
REQ-021 WDEN=0 in COUNT or GRACE SHALL enter IDLE with WDOV kept.
REQ-022 In RESET, WDEN and service SHALL be ignored until the pulse completes.
REQ-023 Service in IDLE SHALL clear WDOV only.
REQ-024 Priorities SHALL be WDEN=0 > service > grace expiry > count-zero overflow.
REQ-025 WDLOAD=0 SHALL cause overflow on the first COUNT cycle.
REQ-026 A WDLOAD change SHALL take effect only at the next reload.
REQ-027 WDOVCLR held at 1 SHALL count as a single service.

Reset
REQ-028 PRESET=1 SHALL force immediately: state IDLE, WDTMR=0, WDOV=0, WDRST_REQ=0, grace and pulse counters 0, WDOVCLR edge flop 0.
REQ-029 Reset asserted mid-RESET pulse SHALL drop WDRST_REQ immediately.
REQ-030 After PRESET deasserts, the first edge SHALL behave as IDLE.

Structure
REQ-031 Package wdt_pkg SHALL hold the state encoding constants and the default GRACE_CYCLES and RST_PULSE values.
REQ-032 The RST_PULSE counter SHALL be a sub-module wdt_rst_stretch (start strobe in, pulse out, busy out).
REQ-033 The grace counter width SHALL be $clog2(GRACE_CYCLES); the pulse counter width SHALL be $clog2(RST_PULSE+1).

Verification
REQ-034 WDLOAD=5, WDEN=1 -> WDTMR sequence 5,4,3,2,1,0, then WDOV=1 and WDSTATE=2 on the next cycle.
REQ-035 Overflow, then a WDOVCLR rise 100 cycles into GRACE -> WDOV=0, WDTMR=WDLOAD, WDSTATE=1, WDRST_REQ never set.
REQ-036 GRACE_CYCLES=8, RST_PULSE=4, no service -> WDRST_REQ high for exactly 4 cycles beginning 8 cycles after WDOV rise; then IDLE with WDOV=1.
REQ-037 Service in the same cycle as WDTMR==0 in COUNT -> no overflow, WDTMR reloads; WDEN=0 on the same cycle as grace expiry -> IDLE, no WDRST_REQ.
REQ-038 PRESET pulsed during cycle 2 of the RESET pulse -> WDRST_REQ=0 and WDSTATE=0 asynchronously; WDLOAD=0 -> overflow on the first COUNT cycle.

Source files
------------

// File: rtl/wdt_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg
// Shared definitions for the 32-bit watchdog controller:
//   - default grace length and reset-pulse width
//   - FSM state encoding (also the WDSTATE debug readback code)
//   - counter width helper, which never returns a zero width
// -----------------------------------------------------------------------------
package wdt_pkg;

   localparam int unsigned WDT_GRACE_CYCLES_DEF = 1024;
   localparam int unsigned WDT_RST_PULSE_DEF    = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_GRACE = 2'd2,
      ST_RESET = 2'd3
   } wdt_state_e;

   // $clog2(n), except that n <= 1 still yields a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wdt_rst_stretch.sv
// -----------------------------------------------------------------------------
// wdt_rst_stretch
// Stretches a one-cycle start strobe into a registered pulse that lasts
// exactly RST_PULSE cycles.
//
// Ports
//   i_clk    in   clock, rising edge
//   i_rst    in   asynchronous active-high reset; drops the pulse at once
//   i_start  in   one-cycle strobe; the pulse rises on the same edge
//   o_pulse  out  registered pulse, high for RST_PULSE cycles
//   o_busy   out  high while the pulse continues past the current cycle;
//                 low in the pulse's final cycle, so a controller can leave
//                 its reset state on the edge where the pulse falls
// -----------------------------------------------------------------------------
module wdt_rst_stretch
   import wdt_pkg::*;
#(
   parameter int unsigned RST_PULSE = WDT_RST_PULSE_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   output logic o_pulse,
   output logic o_busy
);

   localparam int unsigned PW = cnt_width(RST_PULSE + 1);

   logic [PW-1:0] r_cnt;
   logic          r_pulse;

   // r_cnt holds the number of pulse cycles left, including the current one.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else if (i_start) begin
         r_cnt   <= PW'(RST_PULSE);
         r_pulse <= 1'b1;
      end else if (r_cnt != '0) begin
         r_cnt   <= r_cnt - PW'(1);
         r_pulse <= (r_cnt > PW'(1));
      end
   end

   assign o_pulse = r_pulse;
   assign o_busy  = (r_cnt > PW'(1));

endmodule

// File: rtl/wdt32_ctrl.sv
// -----------------------------------------------------------------------------
// wdt32_ctrl
// 32-bit watchdog timer controller. The counter reloads from WDLOAD and runs
// down while enabled. If software fails to service it, the sticky overflow
// flag is set and a grace window opens. If the window also expires without
// service, a system reset request pulse is issued.
//
// Parameters
//   GRACE_CYCLES  cycles from the overflow edge to the reset request edge
//   RST_PULSE     width of WDRST_REQ in cycles
//
// Ports
//   PCLK       in   1   clock, all state changes on its rising edge
//   PRESET     in   1   asynchronous active-high reset
//   WDLOAD     in   32  reload value
//   WDEN       in   1   enable level
//   WDOVCLR    in   1   service level; only its rising edge acts
//   WDTMR      out  32  current count value
//   WDOV       out  1   sticky overflow flag
//   WDRST_REQ  out  1   system reset request pulse
//   WDSTATE    out  2   current FSM state code
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | disabled; WDTMR follows WDLOAD; WDEN=1 starts counting
// COUNT  | counting down; zero sets WDOV and opens the grace window
// GRACE  | overflowed; counter keeps cycling, grace counter runs down
// RESET  | WDRST_REQ pulse in progress; WDEN and service are ignored
//
// Priority inside COUNT/GRACE: WDEN=0 > service > grace expiry > count zero.
// -----------------------------------------------------------------------------
module wdt32_ctrl
   import wdt_pkg::*;
#(
   parameter int unsigned GRACE_CYCLES = WDT_GRACE_CYCLES_DEF,
   parameter int unsigned RST_PULSE    = WDT_RST_PULSE_DEF
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [31:0] WDLOAD,
   input  logic        WDEN,
   input  logic        WDOVCLR,
   output logic [31:0] WDTMR,
   output logic        WDOV,
   output logic        WDRST_REQ,
   output logic [1:0]  WDSTATE
);

   localparam int unsigned GW = cnt_width(GRACE_CYCLES);

   wdt_state_e    r_state;
   logic [31:0]   r_tmr;
   logic          r_ov;
   logic [GW-1:0] r_grace;
   logic          r_clr_d;

   logic          w_svc;
   logic          w_tmr_zero;
   logic          w_expire;
   logic          w_pulse;
   logic          w_busy;

   // A service is a rising edge of WDOVCLR, so a held level counts once.
   assign w_svc      = WDOVCLR & ~r_clr_d;
   assign w_tmr_zero = (r_tmr == 32'd0);

   // Grace window runs out with nothing of higher priority pending. This is
   // also the start strobe of the pulse stretcher, so WDRST_REQ rises on the
   // same edge the FSM enters RESET.
   assign w_expire = (r_state == ST_GRACE) && WDEN && !w_svc
                     && (r_grace == '0);

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state <= ST_IDLE;
         r_tmr   <= 32'd0;
         r_ov    <= 1'b0;
         r_grace <= '0;
         r_clr_d <= 1'b0;
      end else begin
         r_clr_d <= WDOVCLR;
         case (r_state)
            ST_IDLE: begin
               r_tmr <= WDLOAD;
               if (w_svc) begin
                  r_ov <= 1'b0;
               end
               if (WDEN) begin
                  r_state <= ST_COUNT;
               end
            end

            ST_COUNT: begin
               if (!WDEN) begin
                  r_state <= ST_IDLE;
               end else if (w_svc) begin
                  r_ov  <= 1'b0;
                  r_tmr <= WDLOAD;
               end else if (w_tmr_zero) begin
                  r_ov    <= 1'b1;
                  r_tmr   <= WDLOAD;
                  r_grace <= GW'(GRACE_CYCLES - 1);
                  r_state <= ST_GRACE;
               end else begin
                  r_tmr <= r_tmr - 32'd1;
               end
            end

            ST_GRACE: begin
               if (!WDEN) begin
                  r_state <= ST_IDLE;
               end else if (w_svc) begin
                  r_ov    <= 1'b0;
                  r_tmr   <= WDLOAD;
                  r_state <= ST_COUNT;
               end else begin
                  // Counter keeps cycling through WDLOAD; a second zero has
                  // no further effect while the grace window is open.
                  r_tmr <= w_tmr_zero ? WDLOAD : (r_tmr - 32'd1);
                  if (r_grace == '0) begin
                     r_state <= ST_RESET;
                  end else begin
                     r_grace <= r_grace - GW'(1);
                  end
               end
            end

            ST_RESET: begin
               // Leave on the edge where the pulse falls; WDOV stays set.
               if (!w_busy) begin
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   wdt_rst_stretch #(
      .RST_PULSE (RST_PULSE)
   ) u_rst_stretch (
      .i_clk   (PCLK),
      .i_rst   (PRESET),
      .i_start (w_expire),
      .o_pulse (w_pulse),
      .o_busy  (w_busy)
   );

   assign WDTMR     = r_tmr;
   assign WDOV      = r_ov;
   assign WDRST_REQ = w_pulse;
   assign WDSTATE   = r_state;

endmodule

// File: tb/tb_wdt32_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wdt32_ctrl
// Two controllers share one set of inputs: A with a short grace window and
// pulse (8/4), B with the default parameters. A behavioural model per
// instance predicts all outputs and is compared on every falling edge;
// directed scenarios add hand-computed literal expectations, followed by a
// long randomized run.
// -----------------------------------------------------------------------------
module tb_wdt32_ctrl;

   localparam int G_A = 8;
   localparam int P_A = 4;
   localparam int G_B = 1024;
   localparam int P_B = 16;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b0;
   logic [31:0] WDLOAD = 32'd0;
   logic        WDEN = 1'b0;
   logic        WDOVCLR = 1'b0;

   logic [31:0] tmr_a, tmr_b;
   logic        ov_a, ov_b, rq_a, rq_b;
   logic [1:0]  st_a, st_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 PCLK = ~PCLK;

   wdt32_ctrl #(.GRACE_CYCLES(G_A), .RST_PULSE(P_A)) u_dut_a (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .WDLOAD    (WDLOAD),
      .WDEN      (WDEN),
      .WDOVCLR   (WDOVCLR),
      .WDTMR     (tmr_a),
      .WDOV      (ov_a),
      .WDRST_REQ (rq_a),
      .WDSTATE   (st_a)
   );

   wdt32_ctrl u_dut_b (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .WDLOAD    (WDLOAD),
      .WDEN      (WDEN),
      .WDOVCLR   (WDOVCLR),
      .WDTMR     (tmr_b),
      .WDOV      (ov_b),
      .WDRST_REQ (rq_b),
      .WDSTATE   (st_b)
   );

   // ph: 0 idle, 1 counting, 2 overflowed/grace, 3 reset pulse
   // since: edges elapsed since the overflow edge
   // pulse_left: reset-request cycles still to come, including the current one
   typedef struct {
      int     ph;
      longint tmr;
      bit     ov;
      int     since;
      int     pulse_left;
   } mdl_t;

   mdl_t m_a, m_b;
   bit   m_prev;

   function automatic mdl_t mdl_zero();
      mdl_t z;
      z.ph = 0; z.tmr = 0; z.ov = 0; z.since = 0; z.pulse_left = 0;
      return z;
   endfunction

   function automatic mdl_t model_step(mdl_t s, int g, int p, bit en,
                                       bit svc, longint ld);
      mdl_t n = s;
      if (s.ph == 3) begin
         n.pulse_left = s.pulse_left - 1;
         if (n.pulse_left == 0) n.ph = 0;
      end else if (s.ph == 0) begin
         n.tmr = ld;
         if (svc) n.ov = 0;
         if (en) n.ph = 1;
      end else if (!en) begin
         n.ph = 0;
      end else if (svc) begin
         n.ov = 0;
         n.tmr = ld;
         n.ph = 1;
      end else if (s.ph == 1) begin
         if (s.tmr == 0) begin
            n.ov = 1; n.tmr = ld; n.ph = 2; n.since = 0;
         end else begin
            n.tmr = s.tmr - 1;
         end
      end else begin
         n.tmr = (s.tmr == 0) ? ld : s.tmr - 1;
         if (s.since + 1 == g) begin
            n.ph = 3;
            n.pulse_left = p;
         end else begin
            n.since = s.since + 1;
         end
      end
      return n;
   endfunction

   always @(posedge PCLK or posedge PRESET) begin
      bit svc;
      if (PRESET) begin
         m_a = mdl_zero();
         m_b = mdl_zero();
         m_prev = 0;
      end else begin
         svc = WDOVCLR && !m_prev;
         m_a = model_step(m_a, G_A, P_A, WDEN, svc, longint'(WDLOAD));
         m_b = model_step(m_b, G_B, P_B, WDEN, svc, longint'(WDLOAD));
         m_prev = WDOVCLR;
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge PCLK) begin
      chk("tmr_a",  tmr_a, m_a.tmr);
      chk("ov_a",   ov_a,  m_a.ov);
      chk("rq_a",   rq_a,  (m_a.ph == 3) ? 1 : 0);
      chk("st_a",   st_a,  m_a.ph);
      chk("tmr_b",  tmr_b, m_b.tmr);
      chk("ov_b",   ov_b,  m_b.ov);
      chk("rq_b",   rq_b,  (m_b.ph == 3) ? 1 : 0);
      chk("st_b",   st_b,  m_b.ph);
   end

   // Advance to 3 time units after the next rising edge.
   task automatic tick();
      @(posedge PCLK);
      #3;
   endtask

   task automatic do_reset();
      PRESET = 1'b1;
      tick();
      tick();
      PRESET = 1'b0;
   endtask

   initial begin
      bit rq_seen_b;

      #2;
      do_reset();
      chk("rst_tmr_a", tmr_a, 0);
      chk("rst_st_a",  st_a,  0);
      chk("rst_ov_a",  ov_a,  0);
      chk("rst_rq_a",  rq_a,  0);

      // Countdown 5..0, overflow, grace expiry on A, late service on B.
      WDLOAD = 32'd5; WDEN = 1'b1; WDOVCLR = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("s1_tmr_a", tmr_a, 5 - k);
         chk("s1_tmr_b", tmr_b, 5 - k);
      end
      tick();
      chk("s1_ov_a", ov_a, 1);
      chk("s1_st_a", st_a, 2);
      chk("s1_st_b", st_b, 2);
      rq_seen_b = 0;
      for (int k = 1; k <= 99; k++) begin
         tick();
         if (k <= 12) chk("s1_rq_a", rq_a, (k >= 8 && k <= 11) ? 1 : 0);
         if (k == 12) begin
            chk("s1_idle_st_a", st_a, 0);
            chk("s1_idle_ov_a", ov_a, 1);
         end
         if (rq_b) rq_seen_b = 1;
      end
      WDOVCLR = 1'b1;
      tick();
      chk("s1_svc_ov_b",  ov_b,  0);
      chk("s1_svc_tmr_b", tmr_b, 5);
      chk("s1_svc_st_b",  st_b,  1);
      chk("s1_no_rq_b",   rq_seen_b, 0);

      // Service on the zero cycle, held clear, WDEN drop at grace expiry.
      do_reset();
      WDLOAD = 32'd3; WDEN = 1'b1; WDOVCLR = 1'b0;
      repeat (4) tick();
      chk("s2_zero_tmr_a", tmr_a, 0);
      WDOVCLR = 1'b1;
      tick();
      chk("s2_svc_tmr_a", tmr_a, 3);
      chk("s2_svc_ov_a",  ov_a,  0);
      chk("s2_svc_st_a",  st_a,  1);
      repeat (4) tick();
      chk("s2_held_ov_a", ov_a, 1);
      chk("s2_held_st_a", st_a, 2);
      repeat (7) tick();
      WDEN = 1'b0;
      tick();
      chk("s2_off_st_a", st_a, 0);
      chk("s2_off_rq_a", rq_a, 0);
      chk("s2_off_ov_a", ov_a, 1);
      tick();
      chk("s2_off2_rq_a", rq_a, 0);

      // WDLOAD=0 overflows at once; reset asserted mid-pulse.
      do_reset();
      WDLOAD = 32'd0; WDEN = 1'b1; WDOVCLR = 1'b0;
      tick();
      chk("s3_st_a", st_a, 1);
      tick();
      chk("s3_ov_a",  ov_a, 1);
      chk("s3_gst_a", st_a, 2);
      repeat (8) tick();
      chk("s3_rq1_a", rq_a, 1);
      chk("s3_rst_st_a", st_a, 3);
      tick();
      chk("s3_rq2_a", rq_a, 1);
      PRESET = 1'b1;
      #1;
      chk("s3_async_rq_a", rq_a, 0);
      chk("s3_async_st_a", st_a, 0);
      chk("s3_async_ov_a", ov_a, 0);
      tick();
      PRESET = 1'b0;

      // Randomized run.
      WDLOAD = 32'd10; WDEN = 1'b1; WDOVCLR = 1'b0;
      for (int c = 0; c < 9000; c++) begin
         tick();
         if (PRESET) begin
            PRESET = 1'b0;
         end else if ($urandom_range(0, 2999) == 0) begin
            PRESET = 1'b1;
         end
         if (WDEN) begin
            if ($urandom_range(0, 399) == 0) WDEN = 1'b0;
         end else if ($urandom_range(0, 19) == 0) begin
            WDEN = 1'b1;
         end
         if (WDOVCLR) begin
            if ($urandom_range(0, 4) == 0) WDOVCLR = 1'b0;
         end else if ($urandom_range(0, 1499) == 0) begin
            WDOVCLR = 1'b1;
         end
         if ($urandom_range(0, 49) == 0) WDLOAD = $urandom_range(0, 60);
      end

      tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
